// File: rtl/bsg_decode_accum_pkg.sv
// bsg_decode_accum_pkg
// Shared definitions for the decode-accumulate block: the two-state control
// enum and the default bitmap width used as the top-level parameter default.
package bsg_decode_accum_pkg;

  localparam int unsigned default_width_lp = 32;

  typedef enum logic {
    e_accum = 1'b0,
    e_full  = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_decode_with_v.sv
// bsg_decode_with_v
// Decodes a binary index into a one-hot mask, gated by a valid bit.
// An index at or beyond width_p yields an all-zero mask.
// Ports:
//   v_i    - decode enable; mask is zero when low
//   addr_i - binary bit index
//   o      - one-hot (or zero) mask, bit k set for addr_i == k
module bsg_decode_with_v #(
  parameter int width_p    = 32,
  parameter int lg_width_p = $clog2(width_p)
) (
  input  logic                  v_i,
  input  logic [lg_width_p-1:0] addr_i,
  output logic [width_p-1:0]    o
);

  // Per-bit equality compare; indices that match no bit position simply
  // produce no hit, which is how out-of-range addresses are dropped.
  for (genvar i = 0; i < width_p; i++) begin : g_dec
    assign o[i] = v_i & (addr_i == lg_width_p'(i));
  end

endmodule

// File: rtl/bsg_decode_accum.sv
// bsg_decode_accum
// Accumulates a group of encoded bit-index beats into a bitmap. Each accepted
// beat sets one bit; the beat flagged last closes the group and the completed
// bitmap is presented (v_o) until the consumer takes it with yumi_i.
// Optional feature: define BSG_DECODE_ACCUM_DUP_CHECK_EN to enable the sticky
// duplicate flag dup_o; otherwise dup_o is tied low.
// Ports:
//   clk_i, reset_i   - clock, asynchronous active-high reset
//   v_i, addr_i      - input beat valid and bit index
//   last_i           - final beat of the group
//   ready_o          - beat accepted when v_i & ready_o (accumulating state)
//   v_o, data_o      - completed bitmap valid and value
//   count_o          - number of distinct bits set in data_o
//   dup_o            - a beat in this group hit an already-set bit
//   yumi_i           - consumer takes data_o (only while v_o)
module bsg_decode_accum
  import bsg_decode_accum_pkg::*;
#(
  parameter int width_p     = default_width_lp,
  parameter int lo_to_hi_p  = 0,
  parameter int lg_width_p  = $clog2(width_p),
  parameter int cnt_width_p = $clog2(width_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [lg_width_p-1:0]  addr_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  output logic [cnt_width_p-1:0] count_o,
  output logic                   dup_o,
  input  logic                   yumi_i
);

  state_e                 state, state_n;
  logic [width_p-1:0]     mask_raw, mask;
  logic [width_p-1:0]     data_r;
  logic [cnt_width_p-1:0] count_r;
  logic                   accept, take, new_bit;

  // ready_o and v_o come straight from the state register, so neither has a
  // combinational path from v_i or yumi_i.
  assign ready_o = (state == e_accum);
  assign v_o     = (state == e_full);
  assign accept  = v_i & ready_o;
  assign take    = yumi_i & v_o;

  bsg_decode_with_v #(
    .width_p   (width_p),
    .lg_width_p(lg_width_p)
  ) decode (
    .v_i   (accept),
    .addr_i(addr_i),
    .o     (mask_raw)
  );

  for (genvar i = 0; i < width_p; i++) begin : g_map
    if (lo_to_hi_p != 0) begin : g_mirror
      assign mask[i] = mask_raw[width_p-1-i];
    end else begin : g_direct
      assign mask[i] = mask_raw[i];
    end
  end

  // The mask is zero unless a beat is accepted in range, so new_bit alone
  // qualifies the count increment.
  assign new_bit = |(mask & ~data_r);

  always_comb begin
    state_n = state;
    case (state)
      e_accum: if (accept && last_i) state_n = e_full;
      e_full:  if (yumi_i)           state_n = e_accum;
      default: state_n = e_accum;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= e_accum;
      data_r  <= '0;
      count_r <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        data_r  <= '0;
        count_r <= '0;
      end else if (accept) begin
        data_r  <= data_r | mask;
        count_r <= count_r + cnt_width_p'(new_bit);
      end
    end
  end

  assign data_o  = data_r;
  assign count_o = count_r;

`ifdef BSG_DECODE_ACCUM_DUP_CHECK_EN
  logic dup_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dup_r <= 1'b0;
    end else if (take) begin
      dup_r <= 1'b0;
    end else if (|(mask & data_r)) begin
      dup_r <= 1'b1;
    end
  end

  assign dup_o = dup_r;
`else
  assign dup_o = 1'b0;
`endif

  // Taking data when nothing is presented is a protocol violation.
  a_yumi_only_when_valid : assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
  );

endmodule

// File: tb/tb_bsg_decode_accum.sv
// tb_bsg_decode_accum
// Directed bench for bsg_decode_accum. Three instances share clock and reset:
//   dut   - width 32, lo_to_hi_p=0 (main scenarios)
//   dut_m - width 32, lo_to_hi_p=1 (mirrored mapping)
//   dut_n - width 5 (index range exceeds width, out-of-range beats)
// Define BSG_DECODE_ACCUM_DUP_CHECK_EN at compile time to exercise dup_o.
module tb_bsg_decode_accum;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

`ifdef BSG_DECODE_ACCUM_DUP_CHECK_EN
  localparam logic exp_dup = 1'b1;
`else
  localparam logic exp_dup = 1'b0;
`endif

  // main instance
  logic        v_i, last_i, yumi_i, ready_o, v_o, dup_o;
  logic [4:0]  addr_i;
  logic [31:0] data_o;
  logic [5:0]  count_o;

  bsg_decode_accum #(.width_p(32), .lo_to_hi_p(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .addr_i(addr_i),
    .last_i(last_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
    .count_o(count_o), .dup_o(dup_o), .yumi_i(yumi_i)
  );

  // mirrored instance
  logic        m_v, m_last, m_yumi, m_ready, m_vo, m_dup;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [5:0]  m_count;

  bsg_decode_accum #(.width_p(32), .lo_to_hi_p(1)) dut_m (
    .clk_i(clk), .reset_i(reset_i), .v_i(m_v), .addr_i(m_addr),
    .last_i(m_last), .ready_o(m_ready), .v_o(m_vo), .data_o(m_data),
    .count_o(m_count), .dup_o(m_dup), .yumi_i(m_yumi)
  );

  // narrow instance: width 5, 3-bit address, 3-bit count
  logic       n_v, n_last, n_yumi, n_ready, n_vo, n_dup;
  logic [2:0] n_addr;
  logic [4:0] n_data;
  logic [2:0] n_count;

  bsg_decode_accum #(.width_p(5), .lo_to_hi_p(0)) dut_n (
    .clk_i(clk), .reset_i(reset_i), .v_i(n_v), .addr_i(n_addr),
    .last_i(n_last), .ready_o(n_ready), .v_o(n_vo), .data_o(n_data),
    .count_o(n_count), .dup_o(n_dup), .yumi_i(n_yumi)
  );

  // advance one rising edge, then settle 1 time unit before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] a, input logic l);
    v_i = 1'b1; addr_i = a; last_i = l;
    tick();
    v_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic take();
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    v_i = 0; addr_i = 0; last_i = 0; yumi_i = 0;
    m_v = 0; m_addr = 0; m_last = 0; m_yumi = 0;
    n_v = 0; n_addr = 0; n_last = 0; n_yumi = 0;
    #12;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", v_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if (dup_o !== 1'b0) begin errors++; $display("FAIL reset_dup: got %b want 0", dup_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_basic();
    beat(5'd3, 1'b0);
    checks++; if (data_o !== 32'h8 || count_o !== 6'd1 || v_o !== 1'b0) begin
      errors++; $display("FAIL basic_partial: got data=%h cnt=%0d v=%b want 8/1/0", data_o, count_o, v_o); end
    beat(5'd7, 1'b0);
    beat(5'd31, 1'b1);
    checks++; if (v_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++; $display("FAIL basic_v: got v=%b rdy=%b want 1/0", v_o, ready_o); end
    checks++; if (data_o !== 32'h8000_0088) begin errors++; $display("FAIL basic_data: got %h want 80000088", data_o); end
    checks++; if (count_o !== 6'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count_o); end
    checks++; if (dup_o !== 1'b0) begin errors++; $display("FAIL basic_dup: got %b want 0", dup_o); end
    take();
    checks++; if (ready_o !== 1'b1 || data_o !== 32'h0) begin
      errors++; $display("FAIL basic_clear: got rdy=%b data=%h want 1/0", ready_o, data_o); end
  endtask

  task automatic test_mirror();
    m_v = 1'b1; m_addr = 5'd0; m_last = 1'b1;
    tick();
    m_v = 1'b0; m_last = 1'b0;
    checks++; if (m_vo !== 1'b1 || m_data !== 32'h8000_0000 || m_count !== 6'd1) begin
      errors++; $display("FAIL mirror: got v=%b data=%h cnt=%0d want 1/80000000/1", m_vo, m_data, m_count); end
    m_yumi = 1'b1;
    tick();
    m_yumi = 1'b0;
    checks++; if (m_ready !== 1'b1 || m_data !== 32'h0) begin
      errors++; $display("FAIL mirror_clear: got rdy=%b data=%h want 1/0", m_ready, m_data); end
  endtask

  task automatic test_dup();
    beat(5'd5, 1'b0);
    beat(5'd5, 1'b1);
    checks++; if (data_o !== 32'h20 || count_o !== 6'd1) begin
      errors++; $display("FAIL dup_data: got data=%h cnt=%0d want 20/1", data_o, count_o); end
    checks++; if (dup_o !== exp_dup) begin errors++; $display("FAIL dup_flag: got %b want %b", dup_o, exp_dup); end
    take();
    checks++; if (dup_o !== 1'b0) begin errors++; $display("FAIL dup_clear: got %b want 0", dup_o); end
  endtask

  task automatic test_out_of_range();
    n_v = 1'b1; n_addr = 3'd6; n_last = 1'b0;
    tick();
    n_addr = 3'd2;
    tick();
    n_addr = 3'd7; n_last = 1'b1;
    tick();
    n_v = 1'b0; n_last = 1'b0;
    checks++; if (n_vo !== 1'b1 || n_data !== 5'b00100 || n_count !== 3'd1 || n_dup !== 1'b0) begin
      errors++; $display("FAIL oor: got v=%b data=%b cnt=%0d dup=%b want 1/00100/1/0", n_vo, n_data, n_count, n_dup); end
    n_yumi = 1'b1;
    tick();
    n_yumi = 1'b0;
  endtask

  task automatic test_hold();
    beat(5'd9, 1'b1);
    v_i = 1'b1; addr_i = 5'd2; last_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ready_o !== 1'b0 || v_o !== 1'b1 || data_o !== 32'h200 || count_o !== 6'd1) begin
        errors++; $display("FAIL hold_%0d: got rdy=%b v=%b data=%h cnt=%0d want 0/1/200/1", i, ready_o, v_o, data_o, count_o); end
    end
    v_i = 1'b0; last_i = 1'b0;
    take();
    checks++; if (ready_o !== 1'b1 || v_o !== 1'b0 || data_o !== 32'h0 || count_o !== 6'd0) begin
      errors++; $display("FAIL hold_release: got rdy=%b v=%b data=%h cnt=%0d want 1/0/0/0", ready_o, v_o, data_o, count_o); end
  endtask

  task automatic test_back_to_back();
    int bubbles;
    bubbles = 0;
    v_i = 1'b1; addr_i = 5'd1; last_i = 1'b1;
    tick();
    checks++; if (v_o !== 1'b1 || data_o !== 32'h2) begin
      errors++; $display("FAIL b2b_first: got v=%b data=%h want 1/2", v_o, data_o); end
    yumi_i = 1'b1; addr_i = 5'd2;
    tick();
    yumi_i = 1'b0;
    if (ready_o === 1'b1 && v_o === 1'b0) bubbles++;
    checks++; if (data_o !== 32'h0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble: got rdy=%b data=%h want 1/0", ready_o, data_o); end
    tick();
    v_i = 1'b0; last_i = 1'b0;
    checks++; if (v_o !== 1'b1 || data_o !== 32'h4 || bubbles !== 1) begin
      errors++; $display("FAIL b2b_second: got v=%b data=%h bubbles=%0d want 1/4/1", v_o, data_o, bubbles); end
    take();
  endtask

  task automatic test_async_reset();
    beat(5'd0, 1'b0);
    beat(5'd1, 1'b0);
    checks++; if (count_o !== 6'd2 || data_o !== 32'h3) begin
      errors++; $display("FAIL areset_pre: got data=%h cnt=%0d want 3/2", data_o, count_o); end
    #2 reset_i = 1'b1;
    #1;
    checks++; if (data_o !== 32'h0 || count_o !== 6'd0 || v_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL areset_now: got data=%h cnt=%0d v=%b rdy=%b want 0/0/0/1", data_o, count_o, v_o, ready_o); end
    #1 reset_i = 1'b0;
    beat(5'd4, 1'b1);
    checks++; if (v_o !== 1'b1 || data_o !== 32'h10 || count_o !== 6'd1) begin
      errors++; $display("FAIL areset_next: got v=%b data=%h cnt=%0d want 1/10/1", v_o, data_o, count_o); end
    take();
  endtask

  initial begin
    test_reset();
    #1;
    test_basic();
    test_mirror();
    test_dup();
    test_out_of_range();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bsg_decode_accum.md
BSG_DECODE_ACCUM -- requirements
Module: bsg_decode_accum

Interface
REQ-001 The block SHALL have parameter width_p, default 32, giving the output bitmap width in bits.
REQ-002 The block SHALL have parameter lo_to_hi_p, default 0: 0 means address k sets bit k; 1 means address k sets bit width_p-1-k.
REQ-003 The block SHALL have derived parameter lg_width_p, default $clog2(width_p), giving the address width.
REQ-004 The block SHALL have derived parameter cnt_width_p, default $clog2(width_p+1), giving the count width.
REQ-005 Port clk_i, input, 1 bit: the single clock.
REQ-006 Port reset_i, input, 1 bit: asynchronous active-high reset.
REQ-007 Port v_i, input, 1 bit: input address beat valid.
REQ-008 Port addr_i, input, lg_width_p bits: encoded bit index.
REQ-009 Port last_i, input, 1 bit: marks the final beat of a group.
REQ-010 Port ready_o, output, 1 bit: the block accepts a beat.
REQ-011 Port v_o, output, 1 bit: the bitmap is complete and valid.
REQ-012 Port data_o, output, width_p bits: the decoded accumulated bitmap.
REQ-013 Port count_o, output, cnt_width_p bits: number of distinct bits set in data_o.
REQ-014 Port dup_o, output, 1 bit: sticky flag, set when any beat in the group targeted an already-set bit.
REQ-015 Port yumi_i, input, 1 bit: the consumer takes data_o; legal only while v_o=1.

Function
REQ-016 The block SHALL have two states, ACCUM and FULL; ready_o=1 exactly in ACCUM and v_o=1 exactly in FULL.
REQ-017 A beat SHALL be accepted on a rising clk_i edge when v_i & ready_o.
REQ-018 An accepted beat SHALL set the mapped bit of the bitmap register; bits already set remain set.
REQ-019 count_o SHALL increment by 1 only when the accepted beat's bit was previously 0.
REQ-020 An accepted beat with addr_i >= width_p SHALL set no bit and change neither count_o nor dup_o, and SHALL still honour last_i.
REQ-021 An accepted beat with last_i=1 SHALL move the state ACCUM->FULL; its own bit is included in data_o when v_o first asserts the next cycle.
REQ-022 In FULL, data_o, count_o and dup_o SHALL hold stable until yumi_i=1.
REQ-023 yumi_i=1 in FULL SHALL, on that edge, clear the bitmap, count_o and dup_o and move the state to ACCUM; ready_o SHALL be 1 the following cycle.
REQ-024 ready_o SHALL have no combinational path from yumi_i or v_i.
REQ-025 In ACCUM, data_o and count_o SHALL show the partial accumulation; the consumer SHALL ignore them while v_o=0.
REQ-026 yumi_i=1 while v_o=0 is illegal and SHALL be flagged by a simulation-only assertion.
REQ-027 Minimum group latency SHALL be one cycle from the last-beat acceptance edge to v_o=1.
REQ-028 Peak throughput SHALL be one beat per cycle, with one bubble cycle per group.

Reset
REQ-029 reset_i=1 SHALL asynchronously force state ACCUM, data_o=0, count_o=0, dup_o=0, v_o=0 and ready_o=1, including mid-group and while in FULL.
REQ-030 After reset_i deasserts, the first rising edge SHALL be able to accept a beat.

Configuration
REQ-031 With macro BSG_DECODE_ACCUM_DUP_CHECK_EN defined, dup_o SHALL be set by the accepting edge of any beat whose mapped bit is already 1, and SHALL clear per REQ-023.
REQ-032 Without BSG_DECODE_ACCUM_DUP_CHECK_EN, dup_o SHALL be tied to 0 and no duplicate-detection logic SHALL be present; all other behaviour SHALL be identical.

Structure
REQ-033 The shared package bsg_decode_accum_pkg SHALL hold the state enum typedef (e_accum, e_full) and the default width constant.
REQ-034 The block SHALL instantiate one sub-module, bsg_decode_with_v (addr_i, v_i -> one-hot mask), to generate the set mask; lo_to_hi_p mirroring SHALL be applied to that mask.

Verification
REQ-035 The bench SHALL cover: beats addr 3, 7, 31(last), width_p=32, lo_to_hi_p=0 -> next cycle v_o=1, data_o=0x80000088, count_o=3, dup_o=0.
REQ-036 The bench SHALL cover: lo_to_hi_p=1, single beat addr 0 with last -> data_o=0x80000000, count_o=1.
REQ-037 The bench SHALL cover: beats 5, 5(last) with DUP_CHECK_EN -> data_o=0x20, count_o=1, dup_o=1; without the macro -> dup_o=0.
REQ-038 The bench SHALL cover: FULL held 4 cycles with v_i=1 -> ready_o=0 and outputs stable; yumi_i pulse -> next cycle ready_o=1, data_o=0, count_o=0.
REQ-039 The bench SHALL cover: back-to-back groups {1(last)}, {2(last)} with yumi_i asserted the cycle v_o rises -> data_o 0x2 then 0x4, one bubble cycle between groups.
REQ-040 The bench SHALL cover: reset_i pulsed asynchronously mid-group (between edges) after beats 0, 1 -> data_o=0, count_o=0, v_o=0 immediately; the next group is unaffected.
